muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit for the EX stage; successor to the ALU-external divider.
//  Executes MULT/MULTU/DIV/DIVU over WIDTH-bit operands in WIDTH+1 cycles with a start/valid handshake.
//  The pipeline stalls on busy_o. The HI/LO write in the ALU path consumes hi_o/lo_o on valid_o.
//  cancel_i aborts an operation in flight on an exception or ERET flush.
// PARAMETERS
//  WIDTH   32        operand width; hi_o/lo_o are WIDTH bits each
//  CNT_W   $clog2(WIDTH)+1  iteration counter width (derived, not overridden)
// PORTS
//  clk       in   1      single clock, all state on rising edge
//  resetn    in   1      asynchronous, active-low reset
//  start_i   in   1      request; sampled only in IDLE
//  op_i      in   2      MD_MULT / MD_MULTU / MD_DIV / MD_DIVU
//  a_i       in   WIDTH  multiplicand / dividend
//  b_i       in   WIDTH  multiplier / divisor
//  cancel_i  in   1      flush; dominates start_i and every state
//  busy_o    out  1      start_i & IDLE, or state==CALC (combinational stall)
//  valid_o   out  1      one-cycle pulse: hi_o/lo_o final
//  hi_o      out  WIDTH  mul: product[2W-1:W]; div: remainder
//  lo_o      out  WIDTH  mul: product[W-1:0];  div: quotient
//  div0_o    out  1      divisor was zero; qualified by valid_o
// BEHAVIOUR
//  Reset: state=IDLE, counter=0. busy_o=0, valid_o=0, hi_o=0, lo_o=0, div0_o=0.
//  FSM IDLE -> CALC -> DONE -> IDLE:
//   IDLE: start_i & !cancel_i: latch op, take |a|,|b| (signed ops), record signs. cnt=0 -> CALC.
//   CALC: one shift-add (mul) or restoring subtract (div) step per cycle, cnt++.
//         After WIDTH steps -> DONE.
//   DONE: fix result signs, register hi_o/lo_o, valid_o=1 for this cycle only -> IDLE.
//   Latency: start at cycle 0 -> valid_o at cycle WIDTH+1. Back-to-back start is accepted
//   in the cycle after DONE.
//  cancel_i in any state: next state IDLE, valid_o=0. hi_o/lo_o hold previous values.
//   cancel_i with start_i in the same cycle: start ignored.
//  Inputs a_i/b_i/op_i are don't-care after the start cycle; they are latched internally.
//  Signed rules, MIPS semantics:
//   - product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa (the dividend).
//   - min/-1: quotient = 0x8000_0000, remainder = 0, no trap.
//  Divide by zero: div0_o=1, lo_o = all ones, hi_o = a_i as given. Latency is still WIDTH+1.
//  Unsigned ops: no sign fixup; 2W-bit product is exact.
//  Outputs hold their last result until the next valid_o; they never glitch mid-CALC.
//  No X on outputs after reset regardless of op_i encoding. An unused encoding is not
//   possible (2-bit op, all four used).
// STRUCTURE
//  mips_defs package:
//   - MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11
//   - FSM state localparams MD_IDLE/MD_CALC/MD_DONE
//  Sub-module muldiv_absfix (combinational, WIDTH param):
//   - conditional two's-complement for operand magnitudes and result sign correction
//   - instantiated for the input and output sides
//  Datapath regs: acc[2*WIDTH:0] shared by mul/div, b_mag, sign bits, op, cnt.
// TESTING
//  Reset: hold resetn=0 with start_i=1 -> busy_o=0, valid_o=0, hi_o=lo_o=0.
//   Release resetn -> IDLE.
//  MULT a=0xFFFF_FFFE(-2), b=3 -> valid_o at cycle 33; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
//   busy_o high cycles 0..32.
//  MULTU a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
//  DIV a=-7(0xFFFF_FFF9), b=2 -> lo=0xFFFF_FFFD(-3), hi=0xFFFF_FFFF(-1).
//   DIV 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0.
//  DIVU a=100, b=0 -> valid_o at cycle 33, div0_o=1, lo=0xFFFF_FFFF, hi=100.
//   Then DIVU 100/7 started next cycle -> lo=14, hi=2, div0_o=0.
//  cancel_i at cycle 10 of DIV -> no valid_o, busy_o=0 next cycle, hi/lo unchanged.
//   Then start+cancel in the same cycle -> ignored.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small decode helpers.
package mips_defs;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic op_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_absfix.sv
// Conditional two's-complement: magnitude of a signed operand on the way in,
// sign restoration of a result on the way out.
module muldiv_absfix #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? -value : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-subtract step
// per cycle on magnitudes, sign fix-up applied to the final step's result.
module muldiv_unit
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div0_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  md_state_e        state;
  md_op_e           op_q;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] b_mag;
  logic [CNT_W-1:0] cnt;
  logic             sa, sb, b_zero;

  // Operand magnitudes are taken straight from the request ports.
  logic             in_signed;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  assign in_signed = op_is_signed(md_op_e'(op_i));

  muldiv_absfix #(.WIDTH(WIDTH)) u_abs_a (
    .neg(in_signed & a_i[WIDTH-1]), .value(a_i), .result(a_mag_in));
  muldiv_absfix #(.WIDTH(WIDTH)) u_abs_b (
    .neg(in_signed & b_i[WIDTH-1]), .value(b_i), .result(b_mag_in));

  // Shift-add step: add b to the high half when the low bit is set, then shift right.
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_mag};
  assign mul_next = acc[0] ? {1'b0, mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]};

  // Restoring-divide step: shift left, subtract when the partial remainder allows.
  logic [WIDTH:0]   div_rem, div_diff;
  logic             div_ge;
  logic [2*WIDTH:0] div_next;

  assign div_rem  = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_rem >= {1'b0, b_mag};
  assign div_diff = div_rem - {1'b0, b_mag};
  assign div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                           : {div_rem,  acc[WIDTH-2:0], 1'b0};

  logic             is_div;
  logic [2*WIDTH:0] acc_next;

  assign is_div   = op_is_div(op_q);
  assign acc_next = is_div ? div_next : mul_next;

  // Sign restoration, fed from the final step so results land in the DONE cycle.
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  muldiv_absfix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg(sa ^ sb), .value(mul_next[2*WIDTH-1:0]), .result(prod_fixed));
  muldiv_absfix #(.WIDTH(WIDTH)) u_fix_quo (
    .neg(sa ^ sb), .value(div_next[WIDTH-1:0]), .result(quo_fixed));
  muldiv_absfix #(.WIDTH(WIDTH)) u_fix_rem (
    .neg(sa), .value(div_next[2*WIDTH-1:WIDTH]), .result(rem_fixed));

  // Gated by resetn so a request held during reset does not stall the pipe.
  assign busy_o = resetn && ((state == MD_IDLE && start_i) || state == MD_CALC);

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // datapath registers are reset too, keeping outputs X-free from the first cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= MD_IDLE;
      op_q    <= MD_MULT;
      acc     <= '0;
      b_mag   <= '0;
      cnt     <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      b_zero  <= 1'b0;
      valid_o <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
      div0_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (cancel_i) begin
        state <= MD_IDLE;
      end else begin
        case (state)
          MD_IDLE: begin
            if (start_i) begin
              op_q   <= md_op_e'(op_i);
              acc    <= {{(WIDTH+1){1'b0}}, a_mag_in};
              b_mag  <= b_mag_in;
              sa     <= in_signed & a_i[WIDTH-1];
              sb     <= in_signed & b_i[WIDTH-1];
              b_zero <= (b_i == '0);
              cnt    <= '0;
              state  <= MD_CALC;
            end
          end
          MD_CALC: begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_STEP) begin
              state   <= MD_DONE;
              valid_o <= 1'b1;
              div0_o  <= is_div & b_zero;
              if (is_div) begin
                hi_o <= rem_fixed;
                lo_o <= b_zero ? '1 : quo_fixed;
              end else begin
                hi_o <= prod_fixed[2*WIDTH-1:WIDTH];
                lo_o <= prod_fixed[WIDTH-1:0];
              end
            end
          end
          MD_DONE: state <= MD_IDLE;
          default: state <= MD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations push expected results,
// a negedge monitor pops and compares whenever valid_o is seen.
module tb_muldiv_unit;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        cancel_i;
  logic        busy_o, valid_o, div0_o;
  logic [31:0] hi_o, lo_o;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .cancel_i(cancel_i), .busy_o(busy_o),
    .valid_o(valid_o), .hi_o(hi_o), .lo_o(lo_o), .div0_o(div0_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every valid_o pulse must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(valid_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi",        64'(hi_o),   64'(e.hi));
        check("lo",        64'(lo_o),   64'(e.lo));
        check("div0",      64'(div0_o), 64'(e.div0));
        check("valid_cyc", 64'(cyc),    64'(e.at));
      end
    end
  end

  // Leaves the caller 1 time unit after the posedge that begins cycle n.
  task automatic goto_cycle(input int n);
    while (cyc < n - 1) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge with the unit idle; returns one cycle later.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic ediv0,
                          output int s);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    s       = cyc;
    sb.push_back('{hi: ehi, lo: elo, div0: ediv0, at: s + 33});
    @(negedge clk);
    check("busy_start", 64'(busy_o), 64'd1);
    goto_cycle(s + 1);
    start_i = 1'b0;
    op_i    = 2'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 64'(sb.size()), 64'd0);
    goto_cycle(cyc + 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    resetn   = 1'b0;
    start_i  = 1'b1;
    cancel_i = 1'b0;
    op_i     = MD_MULT;
    a_i      = 32'd5;
    b_i      = 32'd5;
    repeat (2) @(negedge clk);
    check("rst_busy",  64'(busy_o),  64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_hi",    64'(hi_o),    64'd0);
    check("rst_lo",    64'(lo_o),    64'd0);
    check("rst_div0",  64'(div0_o),  64'd0);
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    goto_cycle(cyc + 2);
    check("idle_busy", 64'(busy_o), 64'd0);

    // MULT -2 * 3 with busy window edges
    start_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, s);
    while (cyc < s + 32) @(negedge clk);
    check("busy_c32", 64'(busy_o), 64'd1);
    @(negedge clk);
    check("busy_c33", 64'(busy_o), 64'd0);
    drain();

    start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, s);
    drain();
    start_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, s);
    drain();
    start_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, s);
    drain();
    start_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, s);
    drain();
    start_op(MD_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, s);
    drain();

    // Divide by zero, then a back-to-back start in the cycle after DONE
    start_op(MD_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, s);
    goto_cycle(s + 34);
    start_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, s);
    drain();

    // Cancel at cycle 10 of a DIV: no result, outputs held
    start_i = 1'b1;
    op_i    = MD_DIV;
    a_i     = 32'd1000;
    b_i     = 32'd3;
    s       = cyc;
    goto_cycle(s + 1);
    start_i = 1'b0;
    goto_cycle(s + 10);
    cancel_i = 1'b1;
    goto_cycle(s + 11);
    cancel_i = 1'b0;
    @(negedge clk);
    check("cancel_busy", 64'(busy_o), 64'd0);
    check("cancel_hi",   64'(hi_o),   64'd2);
    check("cancel_lo",   64'(lo_o),   64'd14);
    repeat (40) @(negedge clk);

    // Start with cancel in the same cycle is ignored
    goto_cycle(cyc + 1);
    start_i  = 1'b1;
    cancel_i = 1'b1;
    op_i     = MD_MULT;
    a_i      = 32'd9;
    b_i      = 32'd9;
    s        = cyc;
    goto_cycle(s + 1);
    start_i  = 1'b0;
    cancel_i = 1'b0;
    @(negedge clk);
    check("startcancel_busy", 64'(busy_o), 64'd0);
    repeat (40) @(negedge clk);
    check("startcancel_hi", 64'(hi_o), 64'd2);
    goto_cycle(cyc + 1);

    // Recovery after the flushes
    start_op(MD_MULT, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, s);
    drain();
    start_op(MD_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, s);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
